// File: rtl/chan_arb_pkg.sv
// Shared constants for the channel arbiter FIFO: arbitration mode encodings,
// statistics counter width and a width helper that is safe for tiny counts.
package chan_arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int STAT_W = 16;

  // $clog2 returns 0 for 1, which would collapse an index field to zero bits.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel synchronous FIFO with registered pointers; the read port shows the
// head entry combinationally and an empty FIFO never forwards push data.
module chan_fifo
  import chan_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = safe_clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB separates the wrapped-full case from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/chan_arb_fifo.sv
// Multi-channel input FIFOs arbitrated onto one registered output stream.
// Define CHAN_ARB_FIFO_STATS_EN to add per-channel saturating handshake counters (stat_count).
module chan_arb_fifo
  import chan_arb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic [NUM_CH-1:0]          fifo_full
`ifdef CHAN_ARB_FIFO_STATS_EN
  ,
  output logic [NUM_CH*STAT_W-1:0]   stat_count
`endif
);

  localparam int CH_W = safe_clog2(NUM_CH);

  logic                ready_en;
  logic [NUM_CH-1:0]   empty;
  logic [NUM_CH-1:0]   full;
  logic [NUM_CH-1:0]   push;
  logic [NUM_CH-1:0]   pop;
  logic [DATA_W-1:0]   head [NUM_CH];
  logic                load;
  logic [CH_W-1:0]     last;
  logic [CH_W-1:0]     start;
  logic [CH_W-1:0]     idx;
  logic [CH_W-1:0]     grant;
  logic                grant_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[g]),
      .push_data (in_data[g*DATA_W +: DATA_W]),
      .pop       (pop[g]),
      .pop_data  (head[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  // ready_en keeps in_ready low through reset and for the release edge itself.
  assign in_ready  = ready_en ? ~full : '0;
  assign fifo_full = full;
  assign push      = in_valid & in_ready;
  assign load      = !out_valid || out_ready;

  // Fixed priority is round-robin searched from a pinned NUM_CH-1 pointer.
  always_comb begin
    start       = (ARB_MODE == ARB_FIXED) ? CH_W'(NUM_CH - 1) : last;
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int unsigned i = NUM_CH; i >= 1; i--) begin
      idx = CH_W'((32'(start) + i) % NUM_CH);
      if (!empty[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && grant_valid) pop = NUM_CH'(1) << grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= CH_W'(NUM_CH - 1);
    end else begin
      ready_en <= 1'b1;
      if (load) begin
        out_valid <= grant_valid;
        if (grant_valid) begin
          out_data <= head[grant];
          out_ch   <= grant;
          last     <= grant;
        end
      end
    end
  end

`ifdef CHAN_ARB_FIFO_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) stat_q[i] <= '0;
    end else if (out_valid && out_ready && (stat_q[out_ch] != '1)) begin
      stat_q[out_ch] <= stat_q[out_ch] + STAT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
    assign stat_count[g*STAT_W +: STAT_W] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_chan_arb_fifo.sv
// Directed self-checking bench for chan_arb_fifo: a round-robin instance and a
// fixed-priority instance share clock and reset.
module tb_chan_arb_fifo;
  import chan_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [3:0]   in_valid, in_ready, fifo_full;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic [3:0]   fx_in_valid, fx_in_ready, fx_fifo_full;
  logic [127:0] fx_in_data;
  logic         fx_out_valid, fx_out_ready;
  logic [31:0]  fx_out_data;
  logic [1:0]   fx_out_ch;
`ifdef CHAN_ARB_FIFO_STATS_EN
  logic [63:0]  stat_count, fx_stat_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chan_arb_fifo #(.NUM_CH(4), .DATA_W(32), .DEPTH(8), .ARB_MODE(ARB_RR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .fifo_full(fifo_full)
`ifdef CHAN_ARB_FIFO_STATS_EN
    , .stat_count(stat_count)
`endif
  );

  chan_arb_fifo #(.NUM_CH(4), .DATA_W(32), .DEPTH(8), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(fx_in_valid), .in_ready(fx_in_ready), .in_data(fx_in_data),
    .out_valid(fx_out_valid), .out_ready(fx_out_ready), .out_data(fx_out_data), .out_ch(fx_out_ch),
    .fifo_full(fx_fifo_full)
`ifdef CHAN_ARB_FIFO_STATS_EN
    , .stat_count(fx_stat_count)
`endif
  );

  function automatic logic [31:0] rr_word(input int c, input int k);
    return 32'hC0DE_0000 + 32'(c * 16 + k);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0; in_data = '0; out_ready = 1'b0;
    fx_in_valid = '0; fx_in_data = '0; fx_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid = '0; in_data = '0; out_ready = 1'b0;
    fx_in_valid = '0; fx_in_data = '0; fx_out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_cmp++; if (out_ch !== 2'd0) begin n_bad++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
    n_cmp++; if (fifo_full !== 4'h0) begin n_bad++; $display("FAIL reset_fifo_full: got %b expected 0000", fifo_full); end
    n_cmp++; if (in_ready !== 4'h0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++; if (in_ready !== 4'h0) begin n_bad++; $display("FAIL release_in_ready_pre_edge: got %b expected 0000", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 4'hF) begin n_bad++; $display("FAIL release_in_ready: got %b expected 1111", in_ready); end
    n_cmp++; if (fx_in_ready !== 4'hF) begin n_bad++; $display("FAIL release_fx_in_ready: got %b expected 1111", fx_in_ready); end
  endtask

  task automatic test_full();
    do_reset();
    // The first word parks in the output register, then eight more fill FIFO 0.
    in_valid = 4'b0001; in_data[31:0] = 32'hF000_0000;
    @(posedge clk); #1;
    in_valid = '0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL full_parked_valid: got %b expected 1", out_valid); end
    for (int k = 1; k <= 8; k++) begin
      in_valid = 4'b0001; in_data[31:0] = 32'hF000_0000 + 32'(k);
      @(posedge clk); #1;
      if (k == 7) begin
        n_cmp++; if (fifo_full[0] !== 1'b0) begin n_bad++; $display("FAIL full_after7: got %b expected 0", fifo_full[0]); end
      end
    end
    n_cmp++; if (fifo_full[0] !== 1'b1) begin n_bad++; $display("FAIL full_after8: got %b expected 1", fifo_full[0]); end
    n_cmp++; if (in_ready[0] !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b expected 0", in_ready[0]); end
    in_data[31:0] = 32'hF000_0009;
    @(posedge clk); #1;
    in_valid = '0;
    n_cmp++; if (fifo_full[0] !== 1'b1) begin n_bad++; $display("FAIL full_after_reject: got %b expected 1", fifo_full[0]); end
    out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'hF000_0000 + 32'(k)) begin
        n_bad++; $display("FAIL full_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", k, out_valid, out_data, 32'hF000_0000 + 32'(k));
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_drain_end: got valid=%b data=%h expected valid=0", out_valid, out_data); end
    out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    in_valid = 4'hF;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = rr_word(c, k);
      @(posedge clk); #1;
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 2'(s % 4) || out_data !== rr_word(s % 4, s / 4)) begin
        n_bad++; $display("FAIL rr_seq[%0d]: got valid=%b ch=%0d data=%h expected valid=1 ch=%0d data=%h", s, out_valid, out_ch, out_data, s % 4, rr_word(s % 4, s / 4));
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rr_end: got valid=%b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_fixed_priority();
    logic [31:0] exp_d;
    logic [1:0]  exp_c;
    do_reset();
    fx_out_ready = 1'b1;
    for (int s = 0; s < 14; s++) begin
      if (s < 6) begin
        fx_in_valid = 4'b0101;
        fx_in_data[31:0]  = 32'h0000_0D00 + 32'(s);
        fx_in_data[95:64] = 32'h0000_0E00 + 32'(s);
      end else begin
        fx_in_valid = '0;
      end
      @(posedge clk); #1;
      if (s == 0 || s == 13) begin
        n_cmp++; if (fx_out_valid !== 1'b0) begin n_bad++; $display("FAIL fixed_idle[%0d]: got valid=%b expected 0", s, fx_out_valid); end
      end else begin
        exp_c = (s <= 6) ? 2'd0 : 2'd2;
        exp_d = (s <= 6) ? 32'h0000_0D00 + 32'(s - 1) : 32'h0000_0E00 + 32'(s - 7);
        n_cmp++;
        if (fx_out_valid !== 1'b1 || fx_out_ch !== exp_c || fx_out_data !== exp_d) begin
          n_bad++; $display("FAIL fixed_seq[%0d]: got valid=%b ch=%0d data=%h expected valid=1 ch=%0d data=%h", s, fx_out_valid, fx_out_ch, fx_out_data, exp_c, exp_d);
        end
      end
    end
    fx_out_ready = 1'b0;
  endtask

  task automatic test_latency_hold();
    do_reset();
    in_valid = 4'b0010; in_data[63:32] = 32'hA5A5_A5A5;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_idle: got valid=%b expected 0", out_valid); end
    @(posedge clk); #1;
    in_valid = '0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_no_bypass: got valid=%b expected 0", out_valid); end
    for (int h = 0; h < 4; h++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'hA5A5_A5A5 || out_ch !== 2'd1) begin
        n_bad++; $display("FAIL lat_hold[%0d]: got valid=%b ch=%0d data=%h expected valid=1 ch=1 data=a5a5a5a5", h, out_valid, out_ch, out_data);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_drained: got valid=%b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      in_valid = (k < 5) ? 4'b1010 : 4'b0010;
      in_data[63:32]  = 32'h1111_0000 + 32'(k);
      in_data[127:96] = 32'h3333_0000 + 32'(k);
      @(posedge clk); #1;
    end
    in_valid = '0;
    n_cmp++; if (fifo_full !== 4'b0010) begin n_bad++; $display("FAIL mid_pre_full: got %b expected 0010", fifo_full); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (fifo_full !== 4'h0) begin n_bad++; $display("FAIL mid_rst_full: got %b expected 0000", fifo_full); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL mid_rst_data: got %h expected 0", out_data); end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 4'hF) begin n_bad++; $display("FAIL mid_release_ready: got %b expected 1111", in_ready); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale[%0d]: got valid=%b data=%h expected valid=0", k, out_valid, out_data); end
    end
    out_ready = 1'b0;
  endtask

`ifdef CHAN_ARB_FIFO_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b0100;
    for (int k = 0; k < 70000; k++) begin
      in_data[95:64] = 32'(k);
      @(posedge clk); #1;
    end
    in_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (stat_count[47:32] !== 16'hFFFF) begin n_bad++; $display("FAIL stats_ch2: got %h expected ffff", stat_count[47:32]); end
    n_cmp++; if ({stat_count[63:48], stat_count[31:0]} !== 48'h0) begin n_bad++; $display("FAIL stats_others: got %h expected 0", {stat_count[63:48], stat_count[31:0]}); end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full();
    test_round_robin();
    test_fixed_priority();
    test_latency_hold();
    test_reset_mid();
`ifdef CHAN_ARB_FIFO_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
